// File: rtl/wl_linebuf3.sv
// Streaming 3-row column generator: two line SRAMs turn a raster pixel stream into
// vertical (row-2, row-1, row) tap triples, two cycles after each accepted pixel.

module wl_sram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_p,
  input  logic          en,
  input  logic          wea,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && wea) mem[addr] <= din;
  end

  // Read-first: dout returns the word held before this cycle's write.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p)   dout <= '0;
    else if (en) dout <= mem[addr];
  end
endmodule

module wl_linebuf3 #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          pix_vld,
  input  logic          pix_sof,
  input  logic          pix_eol,
  input  logic [DW-1:0] pix_dat,
  output logic          tap_vld,
  output logic [DW-1:0] tap_top,
  output logic [DW-1:0] tap_mid,
  output logic [DW-1:0] tap_bot,
  output logic [AW-1:0] tap_col,
  output logic          tap_eol,
  output logic          tap_win_ok,
  output logic          line_ovf
);
  localparam logic [AW-1:0] COL_MAX = '1;
  localparam logic [1:0]    ROW_SAT = 2'd2;

  logic          rst_p;
  logic [AW-1:0] col_q, col_cur, col_nxt;
  logic [1:0]    row_q, row_cur, row_nxt;
  logic          win_cur, ovf_set;

  logic          vld_d1, eol_d1, win_d1;
  logic [AW-1:0] col_d1;
  logic [DW-1:0] dat_d1;
  logic [DW-1:0] sram0_dout;

  assign rst_p = ~rst_b;

  // A sof pixel forces column 0 / row 0 regardless of the running counts.
  always_comb begin
    col_cur = pix_sof ? '0 : col_q;
    row_cur = pix_sof ? 2'd0 : row_q;
    col_nxt = pix_eol ? '0 : col_cur + AW'(1);
    row_nxt = (pix_eol && (row_cur != ROW_SAT)) ? row_cur + 2'd1 : row_cur;
    ovf_set = (col_cur == COL_MAX) && !pix_eol;
    win_cur = (row_cur == ROW_SAT);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      col_q    <= '0;
      row_q    <= '0;
      line_ovf <= 1'b0;
    end else if (pix_vld) begin
      col_q    <= col_nxt;
      row_q    <= row_nxt;
      line_ovf <= (pix_sof ? 1'b0 : line_ovf) | ovf_set;
    end
  end

  // Stage 1: sideband delayed alongside the sram0 read.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_d1 <= 1'b0;
      col_d1 <= '0;
      dat_d1 <= '0;
      eol_d1 <= 1'b0;
      win_d1 <= 1'b0;
    end else begin
      vld_d1 <= pix_vld;
      if (pix_vld) begin
        col_d1 <= col_cur;
        dat_d1 <= pix_dat;
        eol_d1 <= pix_eol;
        win_d1 <= win_cur;
      end
    end
  end

  wl_sram #(.DW(DW), .AW(AW)) u_sram0 (
    .clk   (clk),
    .rst_p (rst_p),
    .en    (pix_vld),
    .wea   (pix_vld),
    .addr  (col_cur),
    .din   (pix_dat),
    .dout  (sram0_dout)
  );

  // sram1 takes the evicted row-1 pixel one cycle later; its output is the row-2 tap.
  wl_sram #(.DW(DW), .AW(AW)) u_sram1 (
    .clk   (clk),
    .rst_p (rst_p),
    .en    (vld_d1),
    .wea   (vld_d1),
    .addr  (col_d1),
    .din   (sram0_dout),
    .dout  (tap_top)
  );

  // Stage 2: outputs hold while tap_vld is low.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tap_vld    <= 1'b0;
      tap_bot    <= '0;
      tap_mid    <= '0;
      tap_col    <= '0;
      tap_eol    <= 1'b0;
      tap_win_ok <= 1'b0;
    end else begin
      tap_vld <= vld_d1;
      if (vld_d1) begin
        tap_bot    <= dat_d1;
        tap_mid    <= sram0_dout;
        tap_col    <= col_d1;
        tap_eol    <= eol_d1;
        tap_win_ok <= win_d1;
      end
    end
  end
endmodule

// File: tb/tb_wl_linebuf3.sv
// Directed bench for wl_linebuf3: full-size instance for tap data, AW=2 instance for overflow.

module tb_wl_linebuf3;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned AWS = 2;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          pix_vld = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
  logic [DW-1:0] pix_dat = '0;

  logic           tap_vld, tap_eol, tap_win_ok, line_ovf;
  logic [DW-1:0]  tap_top, tap_mid, tap_bot;
  logic [AW-1:0]  tap_col;
  logic           tap_vld_s, tap_eol_s, tap_win_ok_s, line_ovf_s;
  logic [DW-1:0]  tap_top_s, tap_mid_s, tap_bot_s;
  logic [AWS-1:0] tap_col_s;

  wl_linebuf3 #(.DW(DW), .AW(AW)) u_dut (
    .clk(clk), .rst_b(rst_b), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_dat(pix_dat), .tap_vld(tap_vld), .tap_top(tap_top), .tap_mid(tap_mid),
    .tap_bot(tap_bot), .tap_col(tap_col), .tap_eol(tap_eol), .tap_win_ok(tap_win_ok),
    .line_ovf(line_ovf)
  );

  wl_linebuf3 #(.DW(DW), .AW(AWS)) u_dut_s (
    .clk(clk), .rst_b(rst_b), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_dat(pix_dat), .tap_vld(tap_vld_s), .tap_top(tap_top_s), .tap_mid(tap_mid_s),
    .tap_bot(tap_bot_s), .tap_col(tap_col_s), .tap_eol(tap_eol_s), .tap_win_ok(tap_win_ok_s),
    .line_ovf(line_ovf_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int col;
    int top;
    int mid;
    int bot;
    int eol;
    int win;
  } tap_t;

  int   cyc = 0;
  tap_t cap_q[$];
  int   iss_q[$];
  int   cols_s[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tap_t t;
    if (rst_b && tap_vld) begin
      t.cyc = cyc;
      t.col = int'(tap_col);
      t.top = int'(tap_top);
      t.mid = int'(tap_mid);
      t.bot = int'(tap_bot);
      t.eol = int'(tap_eol);
      t.win = int'(tap_win_ok);
      cap_q.push_back(t);
    end
    if (rst_b && tap_vld_s) cols_s.push_back(int'(tap_col_s));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_vld = 1'b0;
      pix_sof = 1'b0;
      pix_eol = 1'b0;
    end
  endtask

  task automatic px(input logic sof, input logic eol, input logic [DW-1:0] dat);
    @(negedge clk);
    pix_vld = 1'b1;
    pix_sof = sof;
    pix_eol = eol;
    pix_dat = dat;
    iss_q.push_back(cyc);
  endtask

  task automatic frame(input int rows, input int cols, input bit gaps);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
        px((r == 0) && (c == 0), c == cols - 1, DW'(r * 16 + c));
      end
  endtask

  // Expected triple for (r, c) of a frame with pix = r*16 + c.
  task automatic check_frame(input string tn, input int rows, input int cols);
    int n;
    int r;
    int c;
    tap_t t;
    n = rows * cols;
    chk({tn, "_cnt"}, cap_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i >= cap_q.size() || i >= iss_q.size()) break;
      r = i / cols;
      c = i % cols;
      t = cap_q[i];
      chk($sformatf("%s_lat%0d", tn, i), t.cyc - iss_q[i], 2);
      chk($sformatf("%s_col%0d", tn, i), t.col, c);
      chk($sformatf("%s_bot%0d", tn, i), t.bot, r * 16 + c);
      chk($sformatf("%s_eol%0d", tn, i), t.eol, (c == cols - 1) ? 1 : 0);
      chk($sformatf("%s_win%0d", tn, i), t.win, (r >= 2) ? 1 : 0);
      if (r >= 2) begin
        chk($sformatf("%s_top%0d", tn, i), t.top, (r - 2) * 16 + c);
        chk($sformatf("%s_mid%0d", tn, i), t.mid, (r - 1) * 16 + c);
      end
    end
    chk({tn, "_hold"}, tap_bot, (rows - 1) * 16 + cols - 1);
    cap_q.delete();
    iss_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst_b = 1'b0;
    idle(3);
    chk("rst_vld", tap_vld, 0);
    chk("rst_col", tap_col, 0);
    chk("rst_top", tap_top, 0);
    chk("rst_mid", tap_mid, 0);
    chk("rst_bot", tap_bot, 0);
    chk("rst_win", tap_win_ok, 0);
    chk("rst_ovf", line_ovf, 0);
    rst_b = 1'b1;
    idle(2);

    // T1/T3: continuous 4x4 frame
    frame(4, 4, 1'b0);
    idle(4);
    check_frame("t1", 4, 4);

    // T2: same frame with random gaps
    frame(4, 4, 1'b1);
    idle(4);
    check_frame("t2", 4, 4);

    // T4: 5-pixel line into the AW=2 instance
    cols_s.delete();
    px(1'b1, 1'b0, 8'h40);
    px(1'b0, 1'b0, 8'h41);
    px(1'b0, 1'b0, 8'h42);
    px(1'b0, 1'b0, 8'h43);
    chk("t4_ovf_pre", line_ovf_s, 0);
    px(1'b0, 1'b1, 8'h44);
    idle(4);
    chk("t4_ovf_set", line_ovf_s, 1);
    chk("t4_ovf_big", line_ovf, 0);
    chk("t4_ncol", cols_s.size(), 5);
    if (cols_s.size() == 5) begin
      chk("t4_col3", cols_s[3], 3);
      chk("t4_col4", cols_s[4], 0);
    end
    px(1'b1, 1'b1, 8'h50);
    idle(3);
    chk("t4_ovf_clr", line_ovf_s, 0);
    cap_q.delete();
    iss_q.delete();

    // T5: reset pulse during row 2
    frame(2, 4, 1'b0);
    px(1'b0, 1'b0, 8'h20);
    px(1'b0, 1'b0, 8'h21);
    @(posedge clk);
    #2;
    rst_b   = 1'b0;
    pix_vld = 1'b0;
    pix_sof = 1'b0;
    pix_eol = 1'b0;
    @(negedge clk);
    chk("t5_vld", tap_vld, 0);
    chk("t5_top", tap_top, 0);
    chk("t5_mid", tap_mid, 0);
    chk("t5_bot", tap_bot, 0);
    chk("t5_col", tap_col, 0);
    chk("t5_eol", tap_eol, 0);
    chk("t5_win", tap_win_ok, 0);
    rst_b = 1'b1;
    idle(3);
    chk("t5_drained", tap_vld, 0);
    cap_q.delete();
    iss_q.delete();
    frame(4, 4, 1'b0);
    idle(4);
    check_frame("t5", 4, 4);

    // T6: 1-pixel-wide frame, 3 rows
    frame(3, 1, 1'b0);
    idle(4);
    check_frame("t6", 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
